// File: rtl/ras_pkg.sv
// ras_pkg
// Shared types for the RAS speculative controller slice.
//   ras_ctrl_state_e : controller FSM states (RESET, RUN, RECOVER).
//   ras_op_t         : one stage operation. Its layout matches the stage FIFO
//                      entry: push/pop flags, new TOS address and pushed data.
// The struct is sized for the default stack geometry
// (1024 entries, 32-bit return addresses).
package ras_pkg;

  localparam int RAS_DEPTH      = 1024;
  localparam int RAS_WIDTH      = 32;
  localparam int RAS_ADDR_WIDTH = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } ras_ctrl_state_e;

  typedef struct packed {
    logic                      push;
    logic                      pop;
    logic [RAS_ADDR_WIDTH-1:0] addr;
    logic [RAS_WIDTH-1:0]      data;
  } ras_op_t;

endpackage

// File: rtl/ras_spec_ctrl_if.sv
// ras_spec_ctrl_if
// Frontend-facing handshake bundle of the RAS speculative controller.
//   call_valid/ret_valid/call_addr : predicted call (push) / return (pop)
//   req_ready                      : controller accepts the op this cycle
//   resolve_valid                  : oldest outstanding op retired
//   squash                         : discard all outstanding ops
// master = frontend side, slave = controller side.
interface ras_spec_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             call_valid;
  logic             ret_valid;
  logic [WIDTH-1:0] call_addr;
  logic             req_ready;
  logic             resolve_valid;
  logic             squash;

  modport master (
    output call_valid, ret_valid, call_addr, resolve_valid, squash,
    input  req_ready
  );

  modport slave (
    input  call_valid, ret_valid, call_addr, resolve_valid, squash,
    output req_ready
  );

endinterface

// File: rtl/ras_occ_counter.sv
// ras_occ_counter
// Up/down occupancy counter with synchronous clear and a full flag.
//   clk, reset : clock, synchronous active-low reset
//   clear      : synchronous clear to zero
//   inc, dec   : count up / down; both together leave the count unchanged
//   count      : current occupancy (0..MAX)
//   full       : count == MAX
module ras_occ_counter #(
  parameter  int MAX = 16,
  localparam int W   = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full
);

  logic [W-1:0] count_q;

  // Occupancy register; callers never increment at MAX or decrement at zero.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count_q <= '0;
    end else if (inc && !dec) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign full  = (count_q == W'(MAX));

endmodule

// File: rtl/ras_spec_ctrl.sv
// ras_spec_ctrl
// Speculative-operation controller for one RAS stage. Accepts call/return
// predictions, tracks the speculative TOS, drives the stage push/pop/trigger
// lane, commits in order on retirement and recovers to the committed TOS on
// a squash.
//   clk, reset            : clock, synchronous active-low reset
//   fe (slave)            : frontend handshake (call/ret/resolve/squash, req_ready)
//   stage_head_addr       : stage FIFO head addr_o (TOS of the oldest op)
//   stage_trigger/push/pop/data/addr : stage op lane
//   stage_commit          : retire oldest stage op
//   stage_reset           : stage reset (active-high)
//   stage_ref_addr        : stage base_addr reload value (= commit_tos)
//   spec_tos, commit_tos  : speculative and committed top-of-stack
//   outstanding           : uncommitted op count
//   underflow             : sticky, pop accepted while the stack was empty
module ras_spec_ctrl
  import ras_pkg::*;
#(
  parameter  int SCRATCHPAD_DEPTH = 16,
  parameter  int DEPTH            = 1024,
  parameter  int WIDTH            = 32,
  localparam int ADDR_WIDTH       = $clog2(DEPTH),
  localparam int CNT_WIDTH        = $clog2(SCRATCHPAD_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ras_spec_ctrl_if.slave        fe,
  input  logic [ADDR_WIDTH-1:0] stage_head_addr,
  output logic                  stage_trigger,
  output logic                  stage_push,
  output logic                  stage_pop,
  output logic [WIDTH-1:0]      stage_data,
  output logic [ADDR_WIDTH-1:0] stage_addr,
  output logic                  stage_commit,
  output logic                  stage_reset,
  output logic [ADDR_WIDTH-1:0] stage_ref_addr,
  output logic [ADDR_WIDTH-1:0] spec_tos,
  output logic [ADDR_WIDTH-1:0] commit_tos,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  underflow
);

  localparam int PTR_W = (SCRATCHPAD_DEPTH > 1) ? $clog2(SCRATCHPAD_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_MAX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] TOS_MAX   = ADDR_WIDTH'(DEPTH - 1);

  ras_ctrl_state_e       state;
  logic [ADDR_WIDTH-1:0] spec_tos_q;
  logic [ADDR_WIDTH-1:0] commit_tos_q;
  logic [ADDR_WIDTH:0]   spec_depth;
  logic [ADDR_WIDTH:0]   commit_depth;
  logic                  underflow_q;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [1:0]            pend_kind [SCRATCHPAD_DEPTH];
  logic                  occ_full;
  logic                  in_run;
  logic [ADDR_WIDTH-1:0] next_tos;
  ras_op_t               issue_op;

  // Depth moves only for a pure push or a pure pop; a tail call (both)
  // overwrites the top entry. Saturates at DEPTH and at zero.
  function automatic logic [ADDR_WIDTH:0] step_depth(input logic [ADDR_WIDTH:0] d,
                                                      input logic push,
                                                      input logic pop);
    step_depth = d;
    if (push && !pop && d != DEPTH_MAX) begin
      step_depth = d + 1'b1;
    end else if (pop && !push && d != '0) begin
      step_depth = d - 1'b1;
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(SCRATCHPAD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A held-low reset blocks new work immediately, not just from the next cycle.
  assign in_run        = reset && (state == RUN);
  assign fe.req_ready  = in_run && !fe.squash && !occ_full;
  assign stage_trigger = fe.req_ready && (fe.call_valid || fe.ret_valid);
  assign stage_commit  = in_run && fe.resolve_valid && (outstanding != '0) && !fe.squash;

  // Candidate TOS for this cycle's op, wrapping modulo DEPTH.
  always_comb begin
    next_tos = spec_tos_q;
    if (fe.call_valid && !fe.ret_valid) begin
      next_tos = (spec_tos_q == TOS_MAX) ? '0 : spec_tos_q + 1'b1;
    end else if (fe.ret_valid && !fe.call_valid) begin
      next_tos = (spec_tos_q == '0) ? TOS_MAX : spec_tos_q - 1'b1;
    end
  end

  // The whole op lane is zero unless an op is actually issued.
  always_comb begin
    issue_op = '0;
    if (stage_trigger) begin
      issue_op.push = fe.call_valid;
      issue_op.pop  = fe.ret_valid;
      issue_op.addr = RAS_ADDR_WIDTH'(next_tos);
      issue_op.data = RAS_WIDTH'(fe.call_addr);
    end
  end

  assign stage_push     = issue_op.push;
  assign stage_pop      = issue_op.pop;
  assign stage_addr     = ADDR_WIDTH'(issue_op.addr);
  assign stage_data     = WIDTH'(issue_op.data);
  assign stage_reset    = !reset || (state != RUN);
  assign stage_ref_addr = commit_tos_q;
  assign spec_tos       = spec_tos_q;
  assign commit_tos     = commit_tos_q;
  assign underflow      = underflow_q;

  // Controller FSM plus speculative/committed TOS and depth tracking.
  // RECOVER rolls the speculative view back to the committed one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RESET;
      spec_tos_q   <= '0;
      commit_tos_q <= '0;
      spec_depth   <= '0;
      commit_depth <= '0;
      underflow_q  <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      case (state)
        RESET: begin
          state <= RUN;
        end
        RUN: begin
          if (stage_trigger) begin
            spec_tos_q <= next_tos;
            spec_depth <= step_depth(spec_depth, fe.call_valid, fe.ret_valid);
            if (fe.ret_valid && spec_depth == '0) begin
              underflow_q <= 1'b1;
            end
            wr_ptr <= ptr_next(wr_ptr);
          end
          if (stage_commit) begin
            commit_tos_q <= stage_head_addr;
            commit_depth <= step_depth(commit_depth, pend_kind[rd_ptr][1], pend_kind[rd_ptr][0]);
            rd_ptr       <= ptr_next(rd_ptr);
          end
          if (fe.squash) begin
            state <= RECOVER;
          end
        end
        RECOVER: begin
          spec_tos_q <= commit_tos_q;
          spec_depth <= commit_depth;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          state      <= RUN;
        end
        default: begin
          state <= RESET;
        end
      endcase
    end
  end

  // Push/pop kind of each outstanding op, so a commit can replay its effect
  // on the committed depth.
  always_ff @(posedge clk) begin
    if (stage_trigger) begin
      pend_kind[wr_ptr] <= {fe.call_valid, fe.ret_valid};
    end
  end

  ras_occ_counter #(
    .MAX (SCRATCHPAD_DEPTH)
  ) u_outstanding (
    .clk   (clk),
    .reset (reset),
    .clear (state == RECOVER),
    .inc   (stage_trigger),
    .dec   (stage_commit),
    .count (outstanding),
    .full  (occ_full)
  );

endmodule

// File: tb/tb_ras_spec_ctrl.sv
// tb_ras_spec_ctrl
// Bench for ras_spec_ctrl: directed scenarios followed by random traffic,
// scored against a queue-based stack model. Issued ops are queued as
// expectations and matched by a negedge monitor against the stage lane.
module tb_ras_spec_ctrl;

  localparam int SD    = 16;
  localparam int DEPTH = 1024;
  localparam int WIDTH = 32;
  localparam int AW    = 10;
  localparam int CW    = 5;

  typedef struct {
    bit          push;
    bit          pop;
    int          addr;
    logic [31:0] data;
  } exp_op_t;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0]    stage_head_addr;
  logic             stage_trigger, stage_push, stage_pop, stage_commit, stage_reset;
  logic [WIDTH-1:0] stage_data;
  logic [AW-1:0]    stage_addr, stage_ref_addr, spec_tos, commit_tos;
  logic [CW-1:0]    outstanding;
  logic             underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: phase 0 = held in reset, 1 = running, 2 = recovering.
  int      m_state  = 0;
  int      m_spec   = 0;
  int      m_commit = 0;
  int      m_depth  = 0;
  int      m_cdepth = 0;
  bit      m_under  = 0;
  exp_op_t pend[$];
  exp_op_t exp_q[$];

  bit mon_en     = 0;
  bit exp_ready  = 0;
  bit exp_commit = 0;
  bit exp_sreset = 1;
  bit exp_trig   = 0;

  always #5 clk = ~clk;

  ras_spec_ctrl_if #(.WIDTH(WIDTH)) fe ();

  ras_spec_ctrl #(
    .SCRATCHPAD_DEPTH (SD),
    .DEPTH            (DEPTH),
    .WIDTH            (WIDTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fe              (fe),
    .stage_head_addr (stage_head_addr),
    .stage_trigger   (stage_trigger),
    .stage_push      (stage_push),
    .stage_pop       (stage_pop),
    .stage_data      (stage_data),
    .stage_addr      (stage_addr),
    .stage_commit    (stage_commit),
    .stage_reset     (stage_reset),
    .stage_ref_addr  (stage_ref_addr),
    .spec_tos        (spec_tos),
    .commit_tos      (commit_tos),
    .outstanding     (outstanding),
    .underflow       (underflow)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int depthStep(input int d, input bit push, input bit pop);
    if (push && !pop) return (d < DEPTH) ? d + 1 : d;
    if (pop && !push) return (d > 0) ? d - 1 : 0;
    return d;
  endfunction

  // One clock cycle: drive inputs, predict this cycle's behaviour, advance the
  // model at the edge, then compare the registered state.
  task automatic applyStimulus(input bit c, input bit r, input logic [31:0] a,
                               input bit rv, input bit sq, input bit rst_n);
    bit      run, trig, com;
    exp_op_t op, old;
    reset            = rst_n;
    fe.call_valid    = c;
    fe.ret_valid     = r;
    fe.call_addr     = a;
    fe.resolve_valid = rv;
    fe.squash        = sq;
    stage_head_addr  = (pend.size() != 0) ? AW'(pend[0].addr) : '0;

    run  = rst_n && (m_state == 1);
    trig = run && !sq && (pend.size() < SD) && (c || r);
    com  = run && rv && (pend.size() != 0) && !sq;
    exp_ready  = run && !sq && (pend.size() < SD);
    exp_trig   = trig;
    exp_commit = com;
    exp_sreset = !rst_n || (m_state != 1);
    op.push = c;
    op.pop  = r;
    op.data = a;
    if (c && !r)      op.addr = (m_spec + 1) % DEPTH;
    else if (r && !c) op.addr = (m_spec + DEPTH - 1) % DEPTH;
    else              op.addr = m_spec;
    if (trig) exp_q.push_back(op);
    mon_en = 1;

    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_spec = 0; m_commit = 0; m_depth = 0; m_cdepth = 0; m_under = 0;
      pend.delete();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (com) begin
        old      = pend.pop_front();
        m_commit = old.addr;
        m_cdepth = depthStep(m_cdepth, old.push, old.pop);
      end
      if (trig) begin
        if (r && m_depth == 0) m_under = 1;
        m_depth = depthStep(m_depth, c, r);
        m_spec  = op.addr;
        pend.push_back(op);
      end
      if (sq) m_state = 2;
    end else begin
      m_spec  = m_commit;
      m_depth = m_cdepth;
      pend.delete();
      m_state = 1;
    end
    #1;
    checkOutput("spec_tos", spec_tos, m_spec);
    checkOutput("commit_tos", commit_tos, m_commit);
    checkOutput("stage_ref_addr", stage_ref_addr, m_commit);
    checkOutput("outstanding", outstanding, pend.size());
    checkOutput("underflow", underflow, m_under);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 0, 0, 1);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
  endtask

  // Scoreboard monitor: handshake outputs every cycle, op lane contents
  // against the queued expectations whenever the DUT issues an op.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_op_t e;
      checkOutput("req_ready", fe.req_ready, exp_ready);
      checkOutput("stage_commit", stage_commit, exp_commit);
      checkOutput("stage_reset", stage_reset, exp_sreset);
      checkOutput("stage_trigger", stage_trigger, exp_trig);
      if (stage_trigger && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("stage_push", stage_push, e.push);
        checkOutput("stage_pop", stage_pop, e.pop);
        checkOutput("stage_addr", stage_addr, e.addr);
        checkOutput("stage_data", stage_data, e.data);
      end else if (!stage_trigger) begin
        checkOutput("idle_lane", {stage_push, stage_pop, stage_addr, stage_data}, 0);
        if (exp_trig && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset            = 1'b0;
    fe.call_valid    = 1'b0;
    fe.ret_valid     = 1'b0;
    fe.call_addr     = '0;
    fe.resolve_valid = 1'b0;
    fe.squash        = 1'b0;
    stage_head_addr  = '0;
    @(posedge clk);
    #1;

    $display("[TB] reset and three calls");
    doReset();
    checkOutput("reset_spec_tos", spec_tos, 0);
    applyStimulus(1, 0, 32'h100, 0, 0, 1);
    applyStimulus(1, 0, 32'h200, 0, 0, 1);
    applyStimulus(1, 0, 32'h300, 0, 0, 1);
    checkOutput("plan_spec_tos_3", spec_tos, 3);
    checkOutput("plan_outstanding_3", outstanding, 3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 1, 0, 1);
    checkOutput("plan_commit_tos_3", commit_tos, 3);
    checkOutput("plan_outstanding_0", outstanding, 0);

    $display("[TB] fill scratchpad");
    doReset();
    for (int i = 0; i < SD; i++) applyStimulus(1, 0, 32'h1000 + i, 0, 0, 1);
    checkOutput("full_outstanding", outstanding, SD);
    applyStimulus(1, 0, 32'hdead, 0, 0, 1);
    applyStimulus(1, 0, 32'hbeef, 1, 0, 1);
    checkOutput("full_spec_tos", spec_tos, SD);
    applyStimulus(1, 0, 32'hcafe, 0, 0, 1);
    checkOutput("after_full_spec_tos", spec_tos, SD + 1);

    $display("[TB] tail call");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'h40 + i, 0, 0, 1);
    applyStimulus(1, 1, 32'h77, 0, 0, 1);
    checkOutput("tail_spec_tos", spec_tos, 5);

    $display("[TB] squash recovery");
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 32'h500 + i, 0, 0, 1);
    applyStimulus(0, 0, 32'h0, 1, 0, 1);
    applyStimulus(0, 0, 32'h0, 1, 0, 1);
    checkOutput("sq_commit_tos", commit_tos, 2);
    applyStimulus(1, 0, 32'h999, 0, 1, 1);
    applyStimulus(1, 0, 32'h998, 0, 1, 1);
    checkOutput("recover_spec_tos", spec_tos, 2);
    checkOutput("recover_outstanding", outstanding, 0);
    applyStimulus(1, 0, 32'h600, 0, 0, 1);

    $display("[TB] underflow");
    doReset();
    applyStimulus(0, 1, 32'h0, 0, 0, 1);
    checkOutput("uf_spec_tos", spec_tos, DEPTH - 1);
    checkOutput("uf_flag", underflow, 1);
    applyStimulus(1, 0, 32'h10, 0, 1, 1);
    idle(2);
    checkOutput("uf_sticky", underflow, 1);

    $display("[TB] reset mid-operation");
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 32'h700 + i, 0, 0, 1);
    applyStimulus(1, 0, 32'h7ff, 1, 0, 0);
    checkOutput("midrst_outstanding", outstanding, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    applyStimulus(1, 0, 32'h800, 0, 0, 1);
    checkOutput("midrst_first_call", spec_tos, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      bit c, r, rv, sq, rn;
      c  = ($urandom_range(0, 99) < 45);
      r  = ($urandom_range(0, 99) < 35);
      rv = ($urandom_range(0, 99) < 40);
      sq = ($urandom_range(0, 99) < 3);
      rn = ($urandom_range(0, 199) != 0);
      applyStimulus(c, r, $urandom, rv, sq, rn);
    end
    idle(2);
    mon_en = 0;
    checkOutput("exp_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
